// File: rtl/tag_alloc_arbiter.sv
// tag_alloc_arbiter: round-robin tag grants and free serialisation in front of a shared multi-output tag queue
module tag_alloc_arbiter #(
  parameter int NumReq         = 4,
  parameter int NumTags        = 8,
  parameter int NumTagOut      = 2,
  parameter int MaxOutstanding = 4,
  parameter int TagWidth       = $clog2(NumTags),
  parameter int ReqIdxWidth    = $clog2(NumReq),
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [NumReq*TagWidth-1:0]    req_tag_o,
  input  logic [NumReq-1:0]             free_valid_i,
  input  logic [NumReq*TagWidth-1:0]    free_tag_i,
  output logic [NumReq-1:0]             free_ready_o,
  input  logic [NumTagOut-1:0]          tq_valid_i,
  input  logic [NumTagOut*TagWidth-1:0] tq_tag_i,
  output logic [NumTagOut-1:0]          tq_get_o,
  output logic                          tq_free_o,
  output logic [TagWidth-1:0]           tq_tag_o,
  output logic [NumReq*CntWidth-1:0]    outstanding_o
);
  localparam int SlotWidth  = $clog2(NumTagOut + 1);
  localparam int NumSlotPad = 2 ** SlotWidth;

  logic [ReqIdxWidth-1:0] grant_ptr_q, grant_ptr_d, free_ptr_q, free_ptr_d;
  logic [NumReq-1:0][CntWidth-1:0] cnt_q, cnt_d;
  logic [NumTags-1:0][ReqIdxWidth-1:0] owner_q;
  logic [NumSlotPad-1:0][TagWidth-1:0] slot_tag;
  logic [NumSlotPad-1:0] slot_valid;
  logic [NumReq-1:0][TagWidth-1:0] grant_tag, free_tag;
  logic [NumReq-1:0] elig, grant, free_acc;
  logic [SlotWidth-1:0] n;
  logic [ReqIdxWidth-1:0] idx, fidx, free_idx;
  logic free_any;

  // Slot vectors are padded past NumTagOut with invalid entries so the pairing counter never indexes out of range
  assign slot_valid = NumSlotPad'(tq_valid_i);
  assign slot_tag = (NumSlotPad*TagWidth)'(tq_tag_i);
  assign free_tag = free_tag_i;

  for (genvar r = 0; r < NumReq; r++) begin : g_elig
    assign elig[r] = req_valid_i[r] && cnt_q[r] < CntWidth'(MaxOutstanding);
  end

  // Slots are taken contiguously from 0, so the pairing count alone fixes which slots are consumed
  for (genvar s = 0; s < NumTagOut; s++) begin : g_get
    assign tq_get_o[s] = n > SlotWidth'(s);
  end

  assign req_ready_o = grant;
  assign req_tag_o = grant_tag;
  assign free_ready_o = free_acc;
  assign tq_free_o = free_any;
  assign tq_tag_o = free_any ? free_tag[free_idx] : '0;
  assign outstanding_o = rst_ni ? cnt_q : '0;

  // Pair the n-th eligible requester (from grant_ptr_q) with slot n until the first invalid slot
  always_comb begin
    grant = '0;
    grant_tag = '0;
    grant_ptr_d = grant_ptr_q;
    n = '0;
    idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = ReqIdxWidth'((int'(grant_ptr_q) + k) % NumReq);
      if (rst_ni && elig[idx] && slot_valid[n]) begin
        grant[idx] = 1'b1;
        grant_tag[idx] = slot_tag[n];
        grant_ptr_d = ReqIdxWidth'((int'(idx) + 1) % NumReq);
        n = n + 1'b1;
      end
    end
  end

  // First valid free from free_ptr_q wins the single tag-queue free port
  always_comb begin
    free_acc = '0;
    free_any = 1'b0;
    free_idx = '0;
    free_ptr_d = free_ptr_q;
    fidx = '0;
    for (int k = 0; k < NumReq; k++) begin
      fidx = ReqIdxWidth'((int'(free_ptr_q) + k) % NumReq);
      if (rst_ni && !free_any && free_valid_i[fidx]) begin
        free_any = 1'b1;
        free_acc[fidx] = 1'b1;
        free_idx = fidx;
        free_ptr_d = ReqIdxWidth'((int'(fidx) + 1) % NumReq);
      end
    end
  end

  // Outstanding count per requester, saturating at both ends; grant plus free cancels out
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NumReq; r++)
      cnt_d[r] = (grant[r] && !free_acc[r] && cnt_q[r] != CntWidth'(MaxOutstanding)) ? cnt_q[r] + 1'b1 :
                 (!grant[r] && free_acc[r] && cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : cnt_q[r];
  end

  // Pointers, counters and tag ownership
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      grant_ptr_q <= '0;
      free_ptr_q <= '0;
      cnt_q <= '0;
      owner_q <= '0;
    end else begin
      grant_ptr_q <= grant_ptr_d;
      free_ptr_q <= free_ptr_d;
      cnt_q <= cnt_d;
      for (int r = 0; r < NumReq; r++)
        if (grant[r]) owner_q[grant_tag[r]] <= ReqIdxWidth'(r);
    end
  end

`ifndef SYNTHESIS
  logic [NumReq-1:0] pend_q;
  logic [NumReq-1:0][TagWidth-1:0] pend_tag_q;

  // Protocol checks: free ownership, grant only on request, slot accounting, loser stability
  always_ff @(posedge clk_i) begin
    pend_q <= rst_ni ? (free_valid_i & ~free_acc) : '0;
    pend_tag_q <= free_tag;
    if (rst_ni) begin
      assert ((req_ready_o & ~req_valid_i) == '0);
      assert ($countones(tq_get_o) <= $countones(tq_valid_i));
      if (free_any) assert (owner_q[tq_tag_o] == free_idx && cnt_q[free_idx] != '0);
      for (int r = 0; r < NumReq; r++)
        if (pend_q[r]) assert (free_valid_i[r] && free_tag[r] == pend_tag_q[r]);
    end
  end
`endif
endmodule

// File: tb/tb_tag_alloc_arbiter.sv
// tb_tag_alloc_arbiter: directed vector table, hand sequences and a randomized run against a queue-based model
module tb_tag_alloc_arbiter;
  localparam int NR = 4, NT = 8, MO = 4, TW = 3, CW = 3;
  logic clk = 1'b0, rst_n;
  logic [3:0] req_valid, req_ready, free_valid, free_ready;
  logic [11:0] req_tag, free_tag, outstanding;
  logic [1:0] tq_valid, tq_get;
  logic [5:0] tq_tag;
  logic tq_free;
  logic [2:0] tq_tag_out;
  int passed = 0, total = 0;

  tag_alloc_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_tag_o(req_tag),
    .free_valid_i(free_valid), .free_tag_i(free_tag), .free_ready_o(free_ready),
    .tq_valid_i(tq_valid), .tq_tag_i(tq_tag), .tq_get_o(tq_get),
    .tq_free_o(tq_free), .tq_tag_o(tq_tag_out), .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rv; logic [1:0] tv; logic [2:0] t0, t1;
    logic [3:0] rdy; logic [1:0] get; logic [11:0] tags, outs;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [37:0] obs();
    return {req_ready, req_tag, tq_get, free_ready, tq_free, tq_tag_out, outstanding};
  endfunction

  function automatic logic [37:0] pk(input logic [3:0] rdy, input logic [11:0] tags, input logic [1:0] get,
                                     input logic [3:0] fr, input logic tf, input logic [2:0] tt, input logic [11:0] outs);
    return {rdy, tags, get, fr, tf, tt, outs};
  endfunction

  task automatic drive(input logic [3:0] rv, input logic [1:0] tv, input logic [2:0] t0, input logic [2:0] t1,
                       input logic [3:0] fv, input logic [11:0] ft);
    req_valid = rv; tq_valid = tv; tq_tag = {t1, t0}; free_valid = fv; free_tag = ft;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string name, input logic [37:0] exp);
    @(negedge clk);
    check(name, 64'(obs()), 64'(exp));
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    drive(4'hF, 2'b11, 3'd1, 3'd2, 4'h0, 12'h0);
    for (int c = 0; c < cycles; c++) step_check("reset_zero", '0);
    rst_n = 1'b1;
  endtask

  // Randomized phase model state: counts, pointers, the tag queue contents and held tags
  int cnt_m[NR];
  int gptr, fptr;
  int pool[$];
  int held[NR][$];
  bit pend[NR];
  int pend_tag[NR];

  task automatic random_phase(input int cycles);
    for (int r = 0; r < NR; r++) begin cnt_m[r] = 0; pend[r] = 0; held[r].delete(); end
    gptr = 0; fptr = 0;
    pool.delete();
    for (int t = 0; t < NT; t++) pool.push_back(t);
    for (int c = 0; c < cycles; c++) begin
      logic [3:0] rv, fv, exp_rdy, exp_fr;
      logic [11:0] ft, exp_tags, mask, exp_outs;
      logic [2:0] t0, t1, exp_tt;
      int nav, ng, winner;
      int order_q[$];
      rv = 4'($urandom_range(0, 15));
      nav = pool.size() < 2 ? pool.size() : 2;
      if ($urandom_range(0, 3) == 0) nav = $urandom_range(0, nav);
      t0 = nav > 0 ? 3'(pool[0]) : 3'($urandom_range(0, 7));
      t1 = nav > 1 ? 3'(pool[1]) : 3'($urandom_range(0, 7));
      for (int r = 0; r < NR; r++)
        if (!pend[r] && held[r].size() > 0 && $urandom_range(0, 2) == 0) begin
          int i = $urandom_range(0, held[r].size() - 1);
          pend_tag[r] = held[r][i];
          held[r].delete(i);
          pend[r] = 1;
        end
      fv = '0; ft = '0;
      for (int r = 0; r < NR; r++) if (pend[r]) begin fv[r] = 1'b1; ft[r*TW +: TW] = 3'(pend_tag[r]); end
      drive(rv, nav == 0 ? 2'b00 : nav == 1 ? 2'b01 : 2'b11, t0, t1, fv, ft);
      for (int k = 0; k < NR; k++) begin
        int r = (gptr + k) % NR;
        if (rv[r] && cnt_m[r] < MO) order_q.push_back(r);
      end
      ng = order_q.size() < nav ? order_q.size() : nav;
      exp_rdy = '0; exp_tags = '0; mask = '0;
      for (int g = 0; g < ng; g++) begin
        exp_rdy[order_q[g]] = 1'b1;
        exp_tags[order_q[g]*TW +: TW] = 3'(pool[g]);
        mask[order_q[g]*TW +: TW] = 3'b111;
      end
      winner = -1;
      for (int k = 0; k < NR && winner < 0; k++) if (pend[(fptr + k) % NR]) winner = (fptr + k) % NR;
      exp_fr = '0; exp_tt = '0;
      if (winner >= 0) begin exp_fr[winner] = 1'b1; exp_tt = 3'(pend_tag[winner]); end
      exp_outs = '0;
      for (int r = 0; r < NR; r++) exp_outs[r*CW +: CW] = 3'(cnt_m[r]);
      @(negedge clk);
      check("rand_grant", 64'({req_ready, req_tag & mask, tq_get}), 64'({exp_rdy, exp_tags, 2'((1 << ng) - 1)}));
      check("rand_free", 64'({free_ready, tq_free, winner >= 0 ? tq_tag_out : 3'd0}), 64'({exp_fr, winner >= 0, exp_tt}));
      check("rand_count", 64'(outstanding), 64'(exp_outs));
      for (int g = 0; g < ng; g++) begin
        cnt_m[order_q[g]]++;
        held[order_q[g]].push_back(pool[g]);
      end
      if (ng > 0) gptr = (order_q[ng-1] + 1) % NR;
      repeat (ng) void'(pool.pop_front());
      if (winner >= 0) begin
        cnt_m[winner]--;
        pool.push_back(pend_tag[winner]);
        pend[winner] = 0;
        fptr = (winner + 1) % NR;
      end
      tick();
    end
  endtask

  initial begin
    vecs[0]  = '{4'hF, 2'b11, 3'd0, 3'd1, 4'b0011, 2'b11, 12'h008, 12'h000};
    vecs[1]  = '{4'hF, 2'b11, 3'd2, 3'd3, 4'b1100, 2'b11, 12'h680, 12'h009};
    vecs[2]  = '{4'hF, 2'b11, 3'd4, 3'd5, 4'b0011, 2'b11, 12'h02C, 12'h249};
    vecs[3]  = '{4'hF, 2'b11, 3'd6, 3'd7, 4'b1100, 2'b11, 12'hF80, 12'h252};
    vecs[4]  = '{4'h0, 2'b00, 3'd0, 3'd0, 4'b0000, 2'b00, 12'h000, 12'h492};
    vecs[5]  = '{4'hF, 2'b01, 3'd1, 3'd0, 4'b0001, 2'b01, 12'h001, 12'h492};
    vecs[6]  = '{4'hF, 2'b01, 3'd2, 3'd0, 4'b0010, 2'b01, 12'h010, 12'h493};
    vecs[7]  = '{4'hF, 2'b01, 3'd3, 3'd0, 4'b0100, 2'b01, 12'h0C0, 12'h49B};
    vecs[8]  = '{4'hF, 2'b01, 3'd4, 3'd0, 4'b1000, 2'b01, 12'h800, 12'h4DB};
    vecs[9]  = '{4'hF, 2'b00, 3'd0, 3'd0, 4'b0000, 2'b00, 12'h000, 12'h6DB};
    vecs[10] = '{4'hF, 2'b11, 3'd5, 3'd6, 4'b0011, 2'b11, 12'h035, 12'h6DB};
    vecs[11] = '{4'hF, 2'b11, 3'd7, 3'd0, 4'b1100, 2'b11, 12'h1C0, 12'h6E4};
    vecs[12] = '{4'hF, 2'b11, 3'd1, 3'd2, 4'b0000, 2'b00, 12'h000, 12'h924};

    do_reset(3);
    foreach (vecs[i]) begin
      drive(vecs[i].rv, vecs[i].tv, vecs[i].t0, vecs[i].t1, 4'h0, 12'h0);
      step_check($sformatf("vec%0d", i), pk(vecs[i].rdy, vecs[i].tags, vecs[i].get, 4'h0, 1'b0, 3'd0, vecs[i].outs));
    end

    do_reset(2);
    for (int c = 0; c < 6; c++) begin
      drive(4'b0100, 2'b01, 3'(c), 3'd0, 4'h0, 12'h0);
      step_check($sformatf("cap%0d", c), pk(c < 4 ? 4'b0100 : 4'b0000, c < 4 ? 12'(c << 6) : 12'h0,
                 c < 4 ? 2'b01 : 2'b00, 4'h0, 1'b0, 3'd0, 12'((c < 4 ? c : 4) << 6)));
    end

    do_reset(1);
    drive(4'b1010, 2'b11, 3'd5, 3'd6, 4'h0, 12'h0);
    step_check("contend_grant", pk(4'b1010, 12'hC28, 2'b11, 4'h0, 1'b0, 3'd0, 12'h000));
    drive(4'h0, 2'b00, 3'd0, 3'd0, 4'b1010, 12'hC28);
    step_check("contend_t", pk(4'h0, 12'h0, 2'b00, 4'b0010, 1'b1, 3'd5, 12'h208));
    drive(4'h0, 2'b00, 3'd0, 3'd0, 4'b1000, 12'hC28);
    step_check("contend_t1", pk(4'h0, 12'h0, 2'b00, 4'b1000, 1'b1, 3'd6, 12'h200));
    drive(4'h0, 2'b00, 3'd0, 3'd0, 4'h0, 12'h0);
    step_check("contend_done", pk(4'h0, 12'h0, 2'b00, 4'h0, 1'b0, 3'd0, 12'h000));

    drive(4'b0001, 2'b01, 3'd2, 3'd0, 4'h0, 12'h0);
    step_check("same_hold", pk(4'b0001, 12'h002, 2'b01, 4'h0, 1'b0, 3'd0, 12'h000));
    drive(4'b0001, 2'b01, 3'd3, 3'd0, 4'b0001, 12'h002);
    step_check("same_cycle", pk(4'b0001, 12'h003, 2'b01, 4'b0001, 1'b1, 3'd2, 12'h001));
    drive(4'h0, 2'b00, 3'd0, 3'd0, 4'h0, 12'h0);
    step_check("same_after", pk(4'h0, 12'h0, 2'b00, 4'h0, 1'b0, 3'd0, 12'h001));

    do_reset(2);
    random_phase(2000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
